// File: rtl/pc_fetch_pkg.sv
// Shared types for the PC fetch controller: FSM states and redirect-source priority.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    // Encoded so that a larger value means a higher-priority redirect.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        TRAP   = 2'd3
    } redir_src_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux, target realignment and pending-capture decision.
module pc_next_sel
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              INSTR_BYTES = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_trap,
    input  logic            i_jump,
    input  logic            i_branch,
    input  logic            i_zero,
    input  logic [XLEN-1:0] i_target,
    input  redir_src_e      i_pend_src,
    input  logic [XLEN-1:0] i_pend_tgt,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_sel_pc,
    output redir_src_e      o_live_src,
    output logic [XLEN-1:0] o_live_tgt,
    output logic            o_tgt_misaligned,
    output logic            o_capture
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] w_target_al;
    logic            w_target_odd;

    assign w_target_al  = i_target & ~ALIGN_MASK;
    assign w_target_odd = |(i_target & ALIGN_MASK);
    assign o_next_pc    = i_pc + XLEN'(INSTR_BYTES);

    always_comb begin
        o_live_src       = NONE;
        o_live_tgt       = w_target_al;
        o_tgt_misaligned = 1'b0;
        if (i_trap) begin
            o_live_src = TRAP;
            o_live_tgt = TRAP_VECTOR;
        end else if (i_jump) begin
            o_live_src       = JUMP;
            o_tgt_misaligned = w_target_odd;
        end else if (i_branch && i_zero) begin
            o_live_src       = BRANCH;
            o_tgt_misaligned = w_target_odd;
        end
    end

    always_comb begin
        o_sel_pc = o_next_pc;
        if (o_live_src != NONE)
            o_sel_pc = o_live_tgt;
        else if (i_pend_src != NONE)
            o_sel_pc = i_pend_tgt;
    end

    // Equal priority overwrites so the most recent redirect of a class wins.
    assign o_capture = (o_live_src != NONE) && (o_live_src >= i_pend_src);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: BOOT/FETCH/STALL FSM, PC register, pending redirect and fetch counter.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_branch,
    input  logic             i_zero,
    input  logic             i_jump,
    input  logic             i_trap,
    input  logic [XLEN-1:0]  i_target,
    input  logic             i_imem_ready,
    output logic             o_imem_req,
    output logic [XLEN-1:0]  o_imem_addr,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_next_pc,
    output logic             o_redirect_pending,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_fetch_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fetch_state_e     r_state, w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    redir_src_e       r_pend_src;
    logic [XLEN-1:0]  r_pend_tgt;
    logic             r_misaligned;
    logic [CNT_W-1:0] r_fetch_cnt;

    logic             w_imem_req;
    logic             w_accept;
    logic [XLEN-1:0]  w_next_pc;
    logic [XLEN-1:0]  w_sel_pc;
    redir_src_e       w_live_src;
    logic [XLEN-1:0]  w_live_tgt;
    logic             w_tgt_misaligned;
    logic             w_capture;

    pc_next_sel #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .i_pc             (r_pc),
        .i_trap           (i_trap),
        .i_jump           (i_jump),
        .i_branch         (i_branch),
        .i_zero           (i_zero),
        .i_target         (i_target),
        .i_pend_src       (r_pend_src),
        .i_pend_tgt       (r_pend_tgt),
        .o_next_pc        (w_next_pc),
        .o_sel_pc         (w_sel_pc),
        .o_live_src       (w_live_src),
        .o_live_tgt       (w_live_tgt),
        .o_tgt_misaligned (w_tgt_misaligned),
        .o_capture        (w_capture)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        case (r_state)
            BOOT:    w_state_nxt = FETCH;
            FETCH: begin
                w_imem_req = 1'b1;
                // Stall only takes effect once the outstanding request is accepted.
                if (i_imem_ready)
                    w_state_nxt = i_stall ? STALL : FETCH;
            end
            STALL:   if (!i_stall) w_state_nxt = FETCH;
            default: w_state_nxt = BOOT;
        endcase
    end

    assign w_accept = w_imem_req && i_imem_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_VECTOR;
            r_pend_src   <= NONE;
            r_pend_tgt   <= '0;
            r_misaligned <= 1'b0;
            r_fetch_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_misaligned <= 1'b0;
            if (w_accept) begin
                r_pc         <= w_sel_pc;
                r_pend_src   <= NONE;
                r_misaligned <= w_tgt_misaligned;
                if (r_fetch_cnt != CNT_MAX)
                    r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end else if (r_state == FETCH) begin
                // Address must stay stable while waiting, so redirects are parked.
                if (w_capture) begin
                    r_pend_src   <= w_live_src;
                    r_pend_tgt   <= w_live_tgt;
                    r_misaligned <= w_tgt_misaligned;
                end
            end else if (r_state == STALL) begin
                if (w_live_src != NONE || r_pend_src != NONE)
                    r_pc <= w_sel_pc;
                r_pend_src   <= NONE;
                r_misaligned <= w_tgt_misaligned;
            end
        end
    end

    assign o_imem_req         = w_imem_req;
    assign o_imem_addr        = r_pc;
    assign o_pc               = r_pc;
    assign o_next_pc          = w_next_pc;
    assign o_redirect_pending = (r_pend_src != NONE);
    assign o_misaligned       = r_misaligned;
    assign o_fetch_cnt        = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, narrow-width corner sequence, random vs reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          IB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, br, zero, jmp, trap, rdy;
    logic [31:0] tgt;
    logic        req, pend, mis;
    logic [31:0] addr, pc, npc;
    logic [15:0] cnt;

    pc_fetch_ctrl #(
        .XLEN(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_branch(br), .i_zero(zero),
        .i_jump(jmp), .i_trap(trap), .i_target(tgt), .i_imem_ready(rdy),
        .o_imem_req(req), .o_imem_addr(addr), .o_pc(pc), .o_next_pc(npc),
        .o_redirect_pending(pend), .o_misaligned(mis), .o_fetch_cnt(cnt)
    );

    logic       s_rst, s_stall, s_br, s_zero, s_jmp, s_trap, s_rdy;
    logic [7:0] s_tgt;
    logic       s_req, s_pend, s_mis;
    logic [7:0] s_addr, s_pc, s_npc;
    logic [1:0] s_cnt;

    pc_fetch_ctrl #(
        .XLEN(8), .INSTR_BYTES(4), .RESET_VECTOR(8'h80),
        .TRAP_VECTOR(8'h10), .CNT_W(2)
    ) dut_n (
        .i_clk(clk), .i_reset(s_rst), .i_stall(s_stall), .i_branch(s_br), .i_zero(s_zero),
        .i_jump(s_jmp), .i_trap(s_trap), .i_target(s_tgt), .i_imem_ready(s_rdy),
        .o_imem_req(s_req), .o_imem_addr(s_addr), .o_pc(s_pc), .o_next_pc(s_npc),
        .o_redirect_pending(s_pend), .o_misaligned(s_mis), .o_fetch_cnt(s_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic e_req, input logic [31:0] e_pc,
                              input logic e_pend, input logic e_mis, input int e_cnt);
        chk({tag, ".req"},  32'(req),  32'(e_req));
        chk({tag, ".pc"},   pc,        e_pc);
        chk({tag, ".addr"}, addr,      e_pc);
        chk({tag, ".npc"},  npc,       e_pc + 32'(IB));
        chk({tag, ".pend"}, 32'(pend), 32'(e_pend));
        chk({tag, ".mis"},  32'(mis),  32'(e_mis));
        chk({tag, ".cnt"},  32'(cnt),  32'(e_cnt));
    endtask

    task automatic drive(input logic r, s, b, z, j, t, y, input logic [31:0] g);
        rst = r; stall = s; br = b; zero = z; jmp = j; trap = t; rdy = y; tgt = g;
    endtask

    // One narrow-DUT cycle: drive, clock, then compare.
    task automatic s_step(input string tag, input logic r, y, j, b, z, input logic [7:0] g,
                          input logic e_req, input logic [7:0] e_pc, input logic e_pend,
                          input logic e_mis, input int e_cnt);
        s_rst = r; s_rdy = y; s_jmp = j; s_br = b; s_zero = z; s_tgt = g;
        @(posedge clk); #1;
        chk({tag, ".req"},  32'(s_req),  32'(e_req));
        chk({tag, ".pc"},   32'(s_pc),   32'(e_pc));
        chk({tag, ".addr"}, 32'(s_addr), 32'(e_pc));
        chk({tag, ".npc"},  32'(s_npc),  32'(8'(e_pc + 8'd4)));
        chk({tag, ".pend"}, 32'(s_pend), 32'(e_pend));
        chk({tag, ".mis"},  32'(s_mis),  32'(e_mis));
        chk({tag, ".cnt"},  32'(s_cnt),  32'(e_cnt));
    endtask

    typedef struct {
        logic        rst, stall, br, zero, jmp, trap, rdy;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_pend, e_mis;
        int          e_cnt;
    } vec_t;

    function automatic vec_t v(input logic r, s, b, z, j, t, y, input logic [31:0] g,
                               input logic q, input logic [31:0] p, input logic pd, m, input int c);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.zero = z; x.jmp = j; x.trap = t; x.rdy = y; x.tgt = g;
        x.e_req = q; x.e_pc = p; x.e_pend = pd; x.e_mis = m; x.e_cnt = c;
        return x;
    endfunction

    // Reference model: architectural view of the fetch unit, stepped once per clock edge.
    logic        m_boot, m_stl, m_mis;
    logic [31:0] m_pc, m_ptgt;
    int          m_pprio, m_cnt;

    task automatic model_step();
        int          lp;
        logic [31:0] lt;
        logic        odd;
        if (rst) begin
            m_boot = 1; m_stl = 0; m_pc = RV; m_pprio = 0; m_mis = 0; m_cnt = 0;
            return;
        end
        if (m_boot) begin
            m_boot = 0; m_mis = 0;
            return;
        end
        lp  = trap ? 3 : jmp ? 2 : (br && zero) ? 1 : 0;
        lt  = trap ? TV : (tgt / IB) * IB;
        odd = (lp == 1 || lp == 2) && (tgt % IB != 0);
        m_mis = 0;
        if (!m_stl) begin
            if (rdy) begin
                m_pc    = (lp != 0) ? lt : (m_pprio != 0) ? m_ptgt : m_pc + 32'(IB);
                m_pprio = 0;
                m_mis   = odd;
                if (m_cnt < 65535) m_cnt++;
                m_stl   = stall;
            end else if (lp != 0 && lp >= m_pprio) begin
                m_pprio = lp; m_ptgt = lt; m_mis = odd;
            end
        end else begin
            if (lp != 0) m_pc = lt;
            else if (m_pprio != 0) m_pc = m_ptgt;
            m_pprio = 0;
            m_mis   = odd;
            if (!stall) m_stl = 0;
        end
    endtask

    vec_t vt[$];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
        s_rst = 1; s_stall = 0; s_br = 0; s_zero = 0; s_jmp = 0; s_trap = 0; s_rdy = 0; s_tgt = 8'h0;

        // Narrow build: PC wrap at 2^8, counter saturation at 3, reset mid-wait.
        s_step("n_rst0", 1, 0, 0, 0, 0, 8'h00, 0, 8'h80, 0, 0, 0);
        s_step("n_rst1", 1, 0, 0, 0, 0, 8'h00, 0, 8'h80, 0, 0, 0);
        s_step("n_boot", 0, 1, 0, 0, 0, 8'h00, 1, 8'h80, 0, 0, 0);
        s_step("n_jmp",  0, 1, 1, 0, 0, 8'hFD, 1, 8'hFC, 0, 1, 1);
        chk("n_npc_wrap", 32'(s_npc), 32'h0);
        s_step("n_wrap", 0, 1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 2);
        s_step("n_c3",   0, 1, 0, 0, 0, 8'h00, 1, 8'h04, 0, 0, 3);
        s_step("n_sat",  0, 1, 0, 0, 0, 8'h00, 1, 8'h08, 0, 0, 3);
        s_step("n_sat2", 0, 1, 0, 0, 0, 8'h00, 1, 8'h0C, 0, 0, 3);
        s_step("n_pend", 0, 0, 0, 1, 1, 8'h20, 1, 8'h0C, 1, 0, 3);
        s_step("n_rstw", 1, 0, 0, 0, 0, 8'h00, 0, 8'h80, 0, 0, 0);

        //             rst stl br z jmp trp rdy target        req pc            pnd mis cnt
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h00, 0, 32'h000, 0, 0, 0));
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h00, 0, 32'h000, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h000, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h004, 0, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h008, 0, 0, 2));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 32'h40, 1, 32'h008, 1, 0, 2));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h00, 1, 32'h008, 1, 0, 2));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h00, 1, 32'h008, 1, 0, 2));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h040, 0, 0, 3));
        vt.push_back(v(0, 0, 1, 1, 0, 0, 0, 32'h20, 1, 32'h040, 1, 0, 3));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h00, 1, 32'h040, 1, 0, 3));
        vt.push_back(v(0, 0, 1, 1, 0, 0, 0, 32'h60, 1, 32'h040, 1, 0, 3));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h100, 0, 0, 4));
        vt.push_back(v(0, 0, 1, 0, 0, 0, 1, 32'h80, 1, 32'h104, 0, 0, 5));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 1, 32'h10, 1, 32'h010, 0, 0, 6));
        vt.push_back(v(0, 1, 0, 0, 0, 0, 1, 32'h00, 0, 32'h014, 0, 0, 7));
        vt.push_back(v(0, 1, 0, 0, 1, 0, 1, 32'h33, 0, 32'h030, 0, 1, 7));
        vt.push_back(v(0, 1, 0, 0, 0, 0, 1, 32'h00, 0, 32'h030, 0, 0, 7));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h030, 0, 0, 7));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 32'h45, 1, 32'h030, 1, 1, 7));
        vt.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h00, 0, 32'h000, 0, 0, 0));
        vt.push_back(v(1, 0, 0, 0, 1, 1, 1, 32'h77, 0, 32'h000, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h000, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h004, 0, 0, 1));
        vt.push_back(v(0, 0, 1, 1, 0, 0, 0, 32'h20, 1, 32'h004, 1, 0, 1));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 1, 32'h50, 1, 32'h050, 0, 0, 2));
        vt.push_back(v(0, 1, 0, 0, 0, 1, 1, 32'h00, 0, 32'h100, 0, 0, 3));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 32'h100, 0, 0, 3));

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].stall, vt[i].br, vt[i].zero, vt[i].jmp, vt[i].trap, vt[i].rdy, vt[i].tgt);
            @(posedge clk); #1;
            check_main($sformatf("row%0d", i), vt[i].e_req, vt[i].e_pc, vt[i].e_pend, vt[i].e_mis, vt[i].e_cnt);
        end

        for (int i = 0; i < 3000; i++) begin
            drive((i < 2) || ($urandom_range(99) < 2),
                  $urandom_range(99) < 25, $urandom_range(99) < 20, $urandom_range(99) < 50,
                  $urandom_range(99) < 10, $urandom_range(99) < 5, $urandom_range(99) < 65,
                  32'($urandom_range(1023)));
            @(posedge clk);
            model_step();
            #1;
            check_main($sformatf("rnd%0d", i), !m_boot && !m_stl, m_pc, m_pprio != 0, m_mis, m_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
